// File: rtl/dc_filter_mc.sv
// Multi-channel DC-blocking high-pass filter: one frame per handshake, one channel per cycle through a shared datapath.
// Optional macro DC_FILTER_MC_SAT_EN: saturate instead of wrap, and add the sat_flag output.
module dc_filter_mc #(
  parameter  int N_CH   = 4,
  parameter  int IN_W   = 9,
  parameter  int FRAC_W = 23,
  parameter  int ACC_W  = IN_W + FRAC_W,
  parameter  int K_W    = 5,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   CLK_3M,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*IN_W-1:0]   in_data,
  input  logic [K_W-1:0]         k_shift,
  output logic                   out_valid,
  output logic [CH_W-1:0]        out_ch,
  output logic [ACC_W-1:0]       out_data,
  output logic                   frame_done
`ifdef DC_FILTER_MC_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int KE_W = $clog2(ACC_W);
  localparam int YW   = ACC_W + 2;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [IN_W-1:0]  fbuf   [N_CH];
  logic [IN_W-1:0]  x_prev [N_CH];
  logic [ACC_W-1:0] e_mem  [N_CH];
  logic [CH_W-1:0]  idx;
  logic [KE_W-1:0]  k_eff, k_new, k_rb;
  logic [31:0]      k_ext, k_clamp;
  logic             accept, last;

  logic signed [IN_W-1:0]  x_cur, x_old;
  logic signed [ACC_W-1:0] e_cur;
  logic signed [IN_W:0]    diff;
  logic signed [YW-1:0]    term, e_ext, e_shr, leak, y_full;
  logic                    rnd, ovf;
  logic [ACC_W-1:0]        y_out;

  assign last = (idx == CH_W'(N_CH - 1));

  always_ff @(posedge CLK_3M) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) && reset;
    accept   = in_ready && in_valid;
  end

  // Pole shift clamped to 1..ACC_W-1 when the frame is accepted.
  always_comb begin
    k_ext = 32'(k_shift);
    if (k_ext == 32'd0)        k_clamp = 32'd1;
    else if (k_ext > ACC_W - 1) k_clamp = 32'(ACC_W - 1);
    else                       k_clamp = k_ext;
    k_new = k_clamp[KE_W-1:0];
  end

  // e >>> K is taken into its own signed variable so the rounding add cannot turn it into a logical shift.
  always_comb begin
    x_cur  = fbuf[idx];
    x_old  = x_prev[idx];
    e_cur  = e_mem[idx];
    diff   = {x_cur[IN_W-1], x_cur} - {x_old[IN_W-1], x_old};
    term   = YW'(diff) <<< FRAC_W;
    e_ext  = YW'(e_cur);
    e_shr  = e_ext >>> k_eff;
    k_rb   = k_eff - KE_W'(1);
    rnd    = e_cur[k_rb];
    leak   = e_shr + $signed(YW'(rnd));
    y_full = term + e_ext - leak;
    ovf    = (y_full[YW-1:ACC_W-1] != '0) && (y_full[YW-1:ACC_W-1] != '1);
`ifdef DC_FILTER_MC_SAT_EN
    if (ovf) y_out = y_full[YW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else     y_out = y_full[ACC_W-1:0];
`else
    y_out = y_full[ACC_W-1:0];
`endif
  end

  always_ff @(posedge CLK_3M) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        fbuf[i]   <= '0;
        x_prev[i] <= '0;
        e_mem[i]  <= '0;
      end
      idx        <= '0;
      k_eff      <= KE_W'(1);
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
      frame_done <= 1'b0;
`ifdef DC_FILTER_MC_SAT_EN
      sat_flag   <= 1'b0;
`endif
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef DC_FILTER_MC_SAT_EN
      sat_flag   <= 1'b0;
`endif
      if (accept) begin
        for (int unsigned i = 0; i < N_CH; i++) fbuf[i] <= in_data[i*IN_W +: IN_W];
        k_eff <= k_new;
        idx   <= '0;
      end else if (state_q == RUN) begin
        out_valid   <= 1'b1;
        out_ch      <= idx;
        out_data    <= y_out;
        frame_done  <= last;
        x_prev[idx] <= x_cur;
        e_mem[idx]  <= y_out;
`ifdef DC_FILTER_MC_SAT_EN
        sat_flag    <= ovf;
`endif
        if (!last) idx <= idx + CH_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dc_filter_mc.sv
// Directed bench for dc_filter_mc at default parameters (4 channels, 9-bit in, 32-bit out).
module tb_dc_filter_mc;

  logic        CLK_3M = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] in_data;
  logic [4:0]  k_shift;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [31:0] out_data;
  logic        frame_done;
`ifdef DC_FILTER_MC_SAT_EN
  logic        sat_flag;
`endif

  int errors = 0;
  int checks = 0;

  dc_filter_mc #(.N_CH(4), .IN_W(9), .FRAC_W(23), .K_W(5)) dut (
    .CLK_3M(CLK_3M), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .k_shift(k_shift), .out_valid(out_valid), .out_ch(out_ch),
    .out_data(out_data), .frame_done(frame_done)
`ifdef DC_FILTER_MC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 CLK_3M = ~CLK_3M;

  typedef struct {
    logic         do_rst;
    logic [35:0]  x;
    logic [4:0]   k;
    logic [127:0] y;
    logic         sat0;
  } vec_t;

  localparam int NV = 13;
  vec_t vec [NV];

  function automatic logic [35:0] px(input int a, input int b, input int c, input int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  function automatic logic [127:0] py(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h (%0d) want 0x%08h (%0d) at %0t", name, act, $signed(act), exp, $signed(exp), $time);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK_3M);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK_3M);
    @(negedge CLK_3M);
    reset = 1'b1;
  endtask

  task automatic run_frame(input logic [35:0] x, input logic [4:0] k, input logic [127:0] y, input logic sat0);
    int n;
    n = 0;
    @(negedge CLK_3M);
    while (!in_ready && n < 20) begin
      @(negedge CLK_3M);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = x;
    k_shift  = k;
    @(negedge CLK_3M);
    in_valid = 1'b0;
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_3M);
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_ch", 32'(out_ch), 32'(i));
      chk("out_data", out_data, y[i*32 +: 32]);
      chk("frame_done", 32'(frame_done), (i == 3) ? 32'd1 : 32'd0);
`ifdef DC_FILTER_MC_SAT_EN
      chk("sat_flag", 32'(sat_flag), (i == 0) ? 32'(sat0) : 32'd0);
`endif
    end
  endtask

  initial begin
    logic exp_rdy, exp_vld;
    int   sat_wrap;

    vec[0]  = '{1'b1, px(10, 0, 0, 0), 5'd16, py(83886080, 0, 0, 0), 1'b0};
    vec[1]  = '{1'b0, px(10, 0, 0, 0), 5'd16, py(83884800, 0, 0, 0), 1'b0};
    vec[2]  = '{1'b0, px(10, 0, 0, 0), 5'd16, py(83883520, 0, 0, 0), 1'b0};
    vec[3]  = '{1'b1, px(0, 0, -5, 0), 5'd16, py(0, 0, -41943040, 0), 1'b0};
    vec[4]  = '{1'b0, px(0, 0, -5, 0), 5'd16, py(0, 0, -41942400, 0), 1'b0};
    vec[5]  = '{1'b1, px(10, 0, 0, 0), 5'd0,  py(83886080, 0, 0, 0), 1'b0};
    vec[6]  = '{1'b0, px(10, 0, 0, 0), 5'd0,  py(41943040, 0, 0, 0), 1'b0};
    vec[7]  = '{1'b1, px(-256, 0, 0, 0), 5'd31, py(32'h80000000, 0, 0, 0), 1'b0};
    vec[8]  = '{1'b0, px(255, 0, 0, 0),  5'd31, py(2139095041, 0, 0, 0), 1'b0};
    vec[9]  = '{1'b1, px(255, 0, 0, 0),  5'd31, py(2139095040, 0, 0, 0), 1'b0};
`ifdef DC_FILTER_MC_SAT_EN
    vec[10] = '{1'b0, px(-256, 0, 0, 0), 5'd31, py(32'h80000000, 0, 0, 0), 1'b1};
    sat_wrap = 1;
`else
    vec[10] = '{1'b0, px(-256, 0, 0, 0), 5'd31, py(32'h7FFFFFFF, 0, 0, 0), 1'b0};
    sat_wrap = 0;
`endif
    vec[11] = '{1'b1, px(1, -1, 255, -256), 5'd16, py(8388608, -8388608, 2139095040, 32'h80000000), 1'b0};
    vec[12] = '{1'b0, px(0, 0, 0, 0),       5'd8,  py(-32768, 32768, -8355840, 8388608), 1'b0};

    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    k_shift = 5'd16;
    @(negedge CLK_3M);
    @(negedge CLK_3M);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
`ifdef DC_FILTER_MC_SAT_EN
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
`endif
    reset = 1'b1;
    @(negedge CLK_3M);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int r = 0; r < NV; r++) begin
      if (vec[r].do_rst) do_reset();
      run_frame(vec[r].x, vec[r].k, vec[r].y, vec[r].sat0);
    end

    // Continuous in_valid: one accept per 5 cycles, k_shift wiggled while busy.
    do_reset();
    @(negedge CLK_3M);
    in_data  = px(10, 0, 0, 0);
    k_shift  = 5'd16;
    in_valid = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge CLK_3M);
      exp_rdy = (j % 5 == 4);
      exp_vld = (j % 5 != 0);
      chk("hs_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("hs_out_valid", 32'(out_valid), 32'(exp_vld));
      if (exp_vld) begin
        chk("hs_out_ch", 32'(out_ch), 32'((j % 5) - 1));
        chk("hs_frame_done", 32'(frame_done), 32'(exp_rdy));
        if (j % 5 == 1)
          chk("hs_ch0_data", out_data, (j == 1) ? 32'd83886080 : (j == 6) ? 32'd83884800 : 32'd83883520);
        else
          chk("hs_chN_data", out_data, 32'd0);
      end
      if (j == 14) in_valid = 1'b0;
      k_shift = in_ready ? 5'd16 : 5'd1;
    end

    // Reset after ch1 output aborts the frame and clears state.
    do_reset();
    @(negedge CLK_3M);
    in_data  = px(10, 0, 7, 0);
    k_shift  = 5'd16;
    in_valid = 1'b1;
    @(negedge CLK_3M);
    in_valid = 1'b0;
    @(negedge CLK_3M);
    chk("mr_ch0", out_data, 32'd83886080);
    @(negedge CLK_3M);
    chk("mr_ch1_ch", 32'(out_ch), 32'd1);
    reset = 1'b0;
    @(negedge CLK_3M);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_data", out_data, 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd0);
    chk("mr_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge CLK_3M);
      chk("mr_no_more_out", 32'(out_valid), 32'd0);
    end
    run_frame(px(10, 0, 0, 0), 5'd16, py(83886080, 0, 0, 0), 1'b0);

    if (sat_wrap == 1) $display("note: saturation build");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
